// File: rtl/video_st_pkg.sv
// rtl/video_st_pkg.sv - shared video stream constants, state enum and control-body helpers
// Purpose : definitions shared by the bob line doubler and its line buffer.
// Contents: packet header nibbles, interlace-nibble bit indices, FSM state enum,
//           control-packet body struct with pack/unpack helpers.
package video_st_pkg;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    // Interlace nibble: bit 3 marks interlaced content, bit 2 selects the field.
    localparam int ILACE_BIT_INTERLACED = 3;
    localparam int ILACE_BIT_FIELD      = 2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CTRL_CAP    = 3'd1,
        CTRL_EMIT   = 3'd2,
        DATA_PASS   = 3'd3,
        DATA_REPLAY = 3'd4,
        OTHER_PASS  = 3'd5
    } bob_state_e;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] height;
        logic [3:0]  ilace;
    } ctrl_body_t;

    // Returns the three body beats as {b3, b2, b1}; unused nibbles are zero.
    function automatic logic [71:0] ctrl_pack(input ctrl_body_t c);
        logic [23:0] b1;
        logic [23:0] b2;
        logic [23:0] b3;
        b1 = '0;
        b2 = '0;
        b3 = '0;
        b1[3:0]   = c.width[15:12];
        b1[11:8]  = c.width[11:8];
        b1[19:16] = c.width[7:4];
        b2[3:0]   = c.width[3:0];
        b2[11:8]  = c.height[15:12];
        b2[19:16] = c.height[11:8];
        b3[3:0]   = c.height[7:4];
        b3[11:8]  = c.height[3:0];
        b3[19:16] = c.ilace;
        return {b3, b2, b1};
    endfunction

    function automatic ctrl_body_t ctrl_unpack(input logic [23:0] b1,
                                               input logic [23:0] b2,
                                               input logic [23:0] b3);
        ctrl_body_t c;
        c.width  = {b1[3:0], b1[11:8], b1[19:16], b2[3:0]};
        c.height = {b2[11:8], b2[19:16], b3[3:0], b3[11:8]};
        c.ilace  = b3[19:16];
        return c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - simple dual-port line RAM with one-cycle registered read
// Purpose : holds one video line so it can be replayed after pass-through.
// Ports   : i_clk            clock
//           i_we/i_waddr/i_wdata   write port
//           i_re/i_raddr           read request; o_rdata valid the next cycle
//           o_rdata                registered read data, held while i_re is low
module line_buffer #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Write-first on a same-address collision: a one-pixel line is read back
    // in the very cycle its only pixel is written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bob_line_doubler.sv
// rtl/bob_line_doubler.sv - interlaced-to-progressive bob line doubler on an Avalon-ST video stream
// Purpose : doubles every active line of interlaced fields, rewrites the control
//           packet (height x2, interlace nibble 0), passes everything else through.
// Ports   : clock, reset_n                    clock, async active-low reset
//           asi_in0_data/valid/ready/sop/eop  input stream (ready latency 0)
//           aso_out0_data/valid/ready/sop/eop registered output stream
module bob_line_doubler
    import video_st_pkg::*;
#(
    parameter int MAX_WIDTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] asi_in0_data,
    input  logic        asi_in0_valid,
    output logic        asi_in0_ready,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic [23:0] aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket
);

    bob_state_e r_state;
    bob_state_e w_state_nxt;

    logic        r_run;
    logic [23:0] r_out_data;
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;

    logic [23:0] r_cap_b1;
    logic [23:0] r_cap_b2;
    logic [23:0] r_cap_b3;
    logic [1:0]  r_cap_cnt;
    logic [1:0]  r_emit_cnt;

    logic        r_cfg_valid;
    logic [15:0] r_cfg_width;
    logic        r_cfg_ilaced;

    logic [15:0]   r_col;
    logic [ADDR_W:0] r_rep_idx;
    logic [ADDR_W:0] r_rep_len;
    logic        r_rep_last;

    logic        w_out_free;
    logic        w_consume;
    logic        w_in_fire;
    logic [3:0]  w_hdr;
    ctrl_body_t  w_cap_body;
    ctrl_body_t  w_new_body;
    logic [71:0] w_emit_beats;
    logic        w_col_last;
    logic        w_col_store;
    logic [16:0] w_col_p1;
    logic [ADDR_W:0] w_line_len;
    logic [ADDR_W:0] w_rep_nxt;
    logic        w_rep_done;
    logic [23:0] w_rd_data;

    logic        w_load;
    logic [23:0] w_ld_data;
    logic        w_ld_sop;
    logic        w_ld_eop;
    logic        w_we;
    logic        w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic        w_col_clr;
    logic        w_col_inc;
    logic        w_rep_start;
    logic        w_rep_adv;
    logic        w_cap_clr;
    logic        w_cap_adv;
    logic        w_emit_clr;
    logic        w_emit_adv;
    logic        w_cfg_commit;

    assign w_out_free    = !r_out_valid || aso_out0_ready;
    assign w_consume     = (r_state == IDLE) || (r_state == CTRL_CAP) ||
                           (r_state == DATA_PASS) || (r_state == OTHER_PASS);
    // r_run keeps ready low while reset is held and for the first cycle after.
    assign asi_in0_ready = r_run && w_out_free && w_consume;
    assign w_in_fire     = asi_in0_valid && asi_in0_ready;
    assign w_hdr         = asi_in0_data[3:0];

    assign w_cap_body   = ctrl_unpack(r_cap_b1, r_cap_b2, r_cap_b3);
    assign w_new_body   = {w_cap_body.width, w_cap_body.height[14:0], 1'b0, 4'h0};
    assign w_emit_beats = w_cap_body.ilace[ILACE_BIT_INTERLACED] ? ctrl_pack(w_new_body)
                                                                 : {r_cap_b3, r_cap_b2, r_cap_b1};

    assign w_col_last  = (r_col == (r_cfg_width - 16'd1));
    assign w_col_store = (r_col < 16'(MAX_WIDTH));
    assign w_col_p1    = {1'b0, r_col} + 17'd1;
    // Pixels beyond the buffer are forwarded but not stored, so replay is clamped.
    assign w_line_len  = (w_col_p1 > 17'(MAX_WIDTH)) ? (ADDR_W+1)'(MAX_WIDTH)
                                                     : w_col_p1[ADDR_W:0];
    assign w_rep_nxt   = r_rep_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_rep_done  = (w_rep_nxt == r_rep_len);

    line_buffer #(
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (ADDR_W),
        .DATA_W (24)
    ) u_line_buffer (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (r_col[ADDR_W-1:0]),
        .i_wdata (asi_in0_data),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_ld_data    = '0;
        w_ld_sop     = 1'b0;
        w_ld_eop     = 1'b0;
        w_we         = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = w_rep_nxt[ADDR_W-1:0];
        w_col_clr    = 1'b0;
        w_col_inc    = 1'b0;
        w_rep_start  = 1'b0;
        w_rep_adv    = 1'b0;
        w_cap_clr    = 1'b0;
        w_cap_adv    = 1'b0;
        w_emit_clr   = 1'b0;
        w_emit_adv   = 1'b0;
        w_cfg_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_in_fire && asi_in0_startofpacket) begin
                    if (w_hdr == PKT_CTRL) begin
                        w_cap_clr = 1'b1;
                        if (!asi_in0_endofpacket) begin
                            w_state_nxt = CTRL_CAP;
                        end
                    end else begin
                        w_load    = 1'b1;
                        w_ld_data = asi_in0_data;
                        w_ld_sop  = 1'b1;
                        w_ld_eop  = asi_in0_endofpacket;
                        if (!asi_in0_endofpacket) begin
                            if ((w_hdr == PKT_VIDEO) && r_cfg_valid && r_cfg_ilaced) begin
                                w_state_nxt = DATA_PASS;
                                w_col_clr   = 1'b1;
                            end else begin
                                w_state_nxt = OTHER_PASS;
                            end
                        end
                    end
                end
            end
            CTRL_CAP: begin
                if (w_in_fire) begin
                    w_cap_adv = 1'b1;
                    if (asi_in0_endofpacket) begin
                        // r_cap_cnt counts body beats already captured before this one.
                        if (r_cap_cnt >= 2'd2) begin
                            w_state_nxt = CTRL_EMIT;
                            w_emit_clr  = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            CTRL_EMIT: begin
                if (w_out_free) begin
                    w_load     = 1'b1;
                    w_emit_adv = 1'b1;
                    case (r_emit_cnt)
                        2'd0: begin
                            w_ld_data = {20'h0, PKT_CTRL};
                            w_ld_sop  = 1'b1;
                        end
                        2'd1: w_ld_data = w_emit_beats[23:0];
                        2'd2: w_ld_data = w_emit_beats[47:24];
                        default: begin
                            w_ld_data    = w_emit_beats[71:48];
                            w_ld_eop     = 1'b1;
                            w_cfg_commit = 1'b1;
                            w_state_nxt  = IDLE;
                        end
                    endcase
                end
            end
            DATA_PASS: begin
                if (w_in_fire) begin
                    w_load    = 1'b1;
                    w_ld_data = asi_in0_data;
                    w_we      = w_col_store;
                    w_col_inc = 1'b1;
                    if (w_col_last || asi_in0_endofpacket) begin
                        // Prefetch pixel 0 now so replay runs without a bubble.
                        w_state_nxt = DATA_REPLAY;
                        w_rep_start = 1'b1;
                        w_rd_en     = 1'b1;
                        w_rd_addr   = '0;
                    end
                end
            end
            DATA_REPLAY: begin
                // The RAM output always holds pixel r_rep_idx; advance only when it is taken.
                if (w_out_free) begin
                    w_load    = 1'b1;
                    w_ld_data = w_rd_data;
                    w_ld_eop  = r_rep_last && w_rep_done;
                    w_rd_en   = 1'b1;
                    w_rep_adv = 1'b1;
                    if (w_rep_done) begin
                        if (r_rep_last) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA_PASS;
                            w_col_clr   = 1'b1;
                        end
                    end
                end
            end
            OTHER_PASS: begin
                if (w_in_fire) begin
                    w_load    = 1'b1;
                    w_ld_data = asi_in0_data;
                    w_ld_sop  = asi_in0_startofpacket;
                    w_ld_eop  = asi_in0_endofpacket;
                    if (asi_in0_endofpacket) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run        <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_cap_b1     <= '0;
            r_cap_b2     <= '0;
            r_cap_b3     <= '0;
            r_cap_cnt    <= '0;
            r_emit_cnt   <= '0;
            r_cfg_valid  <= 1'b0;
            r_cfg_width  <= '0;
            r_cfg_ilaced <= 1'b0;
            r_col        <= '0;
            r_rep_idx    <= '0;
            r_rep_len    <= '0;
            r_rep_last   <= 1'b0;
        end else begin
            r_run <= 1'b1;

            if (w_out_free) begin
                r_out_valid <= w_load;
                r_out_sop   <= w_load && w_ld_sop;
                r_out_eop   <= w_load && w_ld_eop;
                if (w_load) begin
                    r_out_data <= w_ld_data;
                end
            end

            if (w_cap_clr) begin
                r_cap_cnt <= '0;
            end else if (w_cap_adv) begin
                case (r_cap_cnt)
                    2'd0:    r_cap_b1 <= asi_in0_data;
                    2'd1:    r_cap_b2 <= asi_in0_data;
                    2'd2:    r_cap_b3 <= asi_in0_data;
                    default: ;
                endcase
                if (r_cap_cnt != 2'd3) begin
                    r_cap_cnt <= r_cap_cnt + 2'd1;
                end
            end

            if (w_emit_clr) begin
                r_emit_cnt <= '0;
            end else if (w_emit_adv) begin
                r_emit_cnt <= r_emit_cnt + 2'd1;
            end

            if (w_cfg_commit) begin
                r_cfg_valid  <= 1'b1;
                r_cfg_width  <= w_cap_body.width;
                r_cfg_ilaced <= w_cap_body.ilace[ILACE_BIT_INTERLACED];
            end

            if (w_col_clr) begin
                r_col <= '0;
            end else if (w_col_inc && (r_col != 16'hFFFF)) begin
                r_col <= r_col + 16'd1;
            end

            if (w_rep_start) begin
                r_rep_idx  <= '0;
                r_rep_len  <= w_line_len;
                r_rep_last <= asi_in0_endofpacket;
            end else if (w_rep_adv) begin
                r_rep_idx <= w_rep_nxt;
            end
        end
    end

    assign aso_out0_data          = r_out_data;
    assign aso_out0_valid         = r_out_valid;
    assign aso_out0_startofpacket = r_out_sop;
    assign aso_out0_endofpacket   = r_out_eop;

endmodule

// File: tb/tb_bob_line_doubler.sv
// tb/tb_bob_line_doubler.sv - scoreboard bench for the bob line doubler
module tb_bob_line_doubler;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [23:0] asi_in0_data;
    logic        asi_in0_valid;
    logic        asi_in0_ready;
    logic        asi_in0_startofpacket;
    logic        asi_in0_endofpacket;
    logic [23:0] aso_out0_data;
    logic        aso_out0_valid;
    logic        aso_out0_ready = 1'b0;
    logic        aso_out0_startofpacket;
    logic        aso_out0_endofpacket;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          toggle_mode = 1'b0;
    logic        sink_hold = 1'b1;
    bit          prev_stall = 1'b0;
    logic [26:0] prev_out = '0;

    bob_line_doubler #(
        .MAX_WIDTH (1024),
        .ADDR_W    (10)
    ) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (asi_in0_valid),
        .asi_in0_ready          (asi_in0_ready),
        .asi_in0_startofpacket  (asi_in0_startofpacket),
        .asi_in0_endofpacket    (asi_in0_endofpacket),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        aso_out0_ready = toggle_mode ? ~aso_out0_ready : sink_hold;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Body beats {b3,b2,b1} built nibble by nibble from the field layout.
    function automatic logic [71:0] ctrl_beats(input logic [15:0] w, input logic [15:0] h,
                                               input logic [3:0] il);
        logic [23:0] b1;
        logic [23:0] b2;
        logic [23:0] b3;
        b1 = {4'h0, w[7:4],   4'h0, w[11:8], 4'h0, w[15:12]};
        b2 = {4'h0, h[11:8],  4'h0, h[15:12], 4'h0, w[3:0]};
        b3 = {4'h0, il,       4'h0, h[3:0],  4'h0, h[7:4]};
        return {b3, b2, b1};
    endfunction

    // Output monitor: samples 1 time unit before each rising edge.
    always begin
        logic [25:0] e;
        @(negedge clock);
        #4;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_stable",
                      {5'b0, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data},
                      {5'b0, prev_out});
            end
            if (aso_out0_valid && aso_out0_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL extra_beat observed=%h expected=none",
                           {aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data});
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_beat",
                          {6'b0, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data},
                          {6'b0, e});
                end
            end
        end
        prev_stall = aso_out0_valid && !aso_out0_ready;
        prev_out   = {aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data};
    end

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        int   n;
        logic acc;
        @(negedge clock);
        asi_in0_data          = d;
        asi_in0_valid         = 1'b1;
        asi_in0_startofpacket = s;
        asi_in0_endofpacket   = e;
        n = 0;
        forever begin
            #4;
            acc = asi_in0_ready;
            @(posedge clock);
            if (acc) break;
            n++;
            if (n > 3000) begin
                checks++;
                assert (acc) else begin
                    errors++;
                    $error("FAIL send_timeout observed=not_ready expected=accept data=%h", d);
                end
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        asi_in0_valid         = 1'b0;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket   = 1'b0;
    endtask

    task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        logic [71:0] b;
        b = ctrl_beats(w, h, il);
        send(24'h00000F, 1'b1, 1'b0);
        send(b[23:0],    1'b0, 1'b0);
        send(b[47:24],   1'b0, 1'b0);
        send(b[71:48],   1'b0, 1'b1);
        idle();
    endtask

    task automatic expect_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                               input bit rewrite);
        logic [71:0] b;
        logic [15:0] h2;
        h2 = 16'(h * 2);
        b  = rewrite ? ctrl_beats(w, h2, 4'h0) : ctrl_beats(w, h, il);
        exp_q.push_back({2'b10, 24'h00000F});
        exp_q.push_back({2'b00, b[23:0]});
        exp_q.push_back({2'b00, b[47:24]});
        exp_q.push_back({2'b01, b[71:48]});
    endtask

    task automatic data_pkt(input int w, input int n, input int base, input bit dbl);
        int start;
        int len;
        exp_q.push_back({2'b10, 24'h000000});
        if (dbl) begin
            start = 0;
            while (start < n) begin
                len = ((n - start) < w) ? (n - start) : w;
                for (int i = 0; i < len; i++) exp_q.push_back({2'b00, 24'(base + start + i)});
                for (int i = 0; i < len; i++)
                    exp_q.push_back({1'b0, ((start + len == n) && (i == len - 1)), 24'(base + start + i)});
                start += len;
            end
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), 24'(base + i)});
        end
        send(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) send(24'(base + i), 1'b0, (i == n - 1));
        idle();
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < 5000)) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n               = 1'b0;
        asi_in0_data          = '0;
        asi_in0_valid         = 1'b0;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket   = 1'b0;
        sink_hold             = 1'b1;

        #2;
        check("reset_out", {5'b0, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
                            aso_out0_data}, 32'd0);
        check("reset_ready", {31'b0, asi_in0_ready}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Interlaced control packet rewrite.
        expect_ctrl(16'd640, 16'd240, 4'hB, 1'b1);
        send_ctrl(16'd640, 16'd240, 4'hB);
        wait_drain("ctrl_640x240");

        // 4x2 field, ramp 1..8, sink always ready.
        expect_ctrl(16'd4, 16'd2, 4'hB, 1'b1);
        send_ctrl(16'd4, 16'd2, 4'hB);
        data_pkt(4, 8, 1, 1'b1);
        wait_drain("double_4x2");

        // Same packet with the sink toggling every cycle.
        toggle_mode = 1'b1;
        data_pkt(4, 8, 1, 1'b1);
        wait_drain("double_4x2_toggle");
        toggle_mode = 1'b0;

        // Progressive control packet and data pass through unchanged.
        expect_ctrl(16'd4, 16'd2, 4'h2, 1'b0);
        send_ctrl(16'd4, 16'd2, 4'h2);
        data_pkt(4, 8, 32'h10, 1'b0);
        wait_drain("progressive_pass");

        // Truncated control packet is discarded; 640-wide config survives.
        begin
            logic [71:0] tb_b;
            expect_ctrl(16'd640, 16'd240, 4'hB, 1'b1);
            send_ctrl(16'd640, 16'd240, 4'hB);
            tb_b = ctrl_beats(16'd4, 16'd2, 4'hB);
            send(24'h00000F, 1'b1, 1'b0);
            send(tb_b[23:0], 1'b0, 1'b0);
            send(tb_b[47:24], 1'b0, 1'b1);
            idle();
            data_pkt(640, 640, 32'h100, 1'b1);
            wait_drain("truncated_ctrl");
        end

        // Asynchronous reset in the middle of a line replay.
        mon_en = 1'b0;
        send_ctrl(16'd4, 16'd2, 4'hB);
        send(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(24'(32'h40 + i), 1'b0, 1'b0);
        @(negedge clock);
        check("replay_active", {31'b0, aso_out0_valid}, 32'd1);
        #2;
        reset_n       = 1'b0;
        asi_in0_valid = 1'b0;
        #1;
        check("async_reset_out", {5'b0, aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket,
                                  aso_out0_data}, 32'd0);
        check("async_reset_ready", {31'b0, asi_in0_ready}, 32'd0);
        repeat (2) @(negedge clock);
        exp_q.delete();
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Config was cleared, so this data packet is not doubled.
        data_pkt(4, 2, 32'h20, 1'b0);
        wait_drain("post_reset_undoubled");
        expect_ctrl(16'd4, 16'd2, 4'hB, 1'b1);
        send_ctrl(16'd4, 16'd2, 4'hB);
        data_pkt(4, 8, 32'h30, 1'b1);
        wait_drain("post_reset_double");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
